fx2_iq_packetizer: RTL

- Sits between the I/Q FIR output and the FX2LP slave-FIFO pins. It buffers 32-bit {Q,I} sample words in an on-chip FIFO and serialises each word into 4 byte writes on the FX2 FD bus.
- It commits short packets with PKTENDN after the stream goes idle, so the host sees data with bounded latency at low decimated rates.
- The upstream DSP chain has no backpressure, so samples that arrive while the FIFO is full are dropped and counted.

---
 rtl/fx2_iq_packetizer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fx2_iq_packetizer.sv
// I/Q sample packetizer for the FX2LP slave FIFO: buffers 32-bit {Q,I} words, sends each as
// four LSB-first byte writes and commits short packets with PKTEND after an idle timeout.
module fx2_iq_packetizer #(
  parameter int unsigned DEPTH_LOG2     = 9,
  parameter int unsigned PKT_BYTES      = 512,
  parameter int unsigned TIMEOUT_CYCLES = 48000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  output logic [7:0]            fd,
  output logic                  slwrn,
  output logic                  pktendn,
  input  logic                  full_n,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           overflow_count,
  input  logic                  clear_overflow
);

  localparam int unsigned LevelW = DEPTH_LOG2 + 1;
  localparam int unsigned CntW   = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LevelW-1:0] Depth    = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StB0, StB1, StB2, StB3, StPktend} state_e;

  logic [31:0]           mem_q [0:(1 << DEPTH_LOG2) - 1];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0]     level_q, level_d;
  logic [15:0]           ovf_q, ovf_d;
  state_e                state_q, state_d;
  logic [31:0]           word_q, word_d;
  logic [7:0]            fd_q, fd_d;
  logic                  slwrn_q, slwrn_d;
  logic                  pktendn_q, pktendn_d;
  logic [CntW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [TimerW-1:0]     timer_q, timer_d;

  logic        fifo_full, fifo_empty, push, drop, pop, can_pop, byte_clr;
  logic [31:0] rd_data;

  assign fifo_full  = (level_q == Depth);
  assign fifo_empty = (level_q == '0);
  assign push       = in_valid & ~fifo_full;
  assign drop       = in_valid & fifo_full;
  assign rd_data    = mem_q[rd_ptr_q];
  assign can_pop    = ~fifo_empty & full_n;

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    fd_d      = fd_q;
    slwrn_d   = 1'b1;
    pktendn_d = 1'b1;
    pop       = 1'b0;
    byte_clr  = 1'b0;
    unique case (state_q)
      StIdle, StB3: begin
        if (can_pop) begin
          pop     = 1'b1;
          word_d  = rd_data;
          fd_d    = rd_data[7:0];
          slwrn_d = 1'b0;
          state_d = StB0;
        end else if (state_q == StIdle && byte_cnt_q != '0 && timer_q == TimerMax && full_n) begin
          pktendn_d = 1'b0;
          state_d   = StPktend;
        end else begin
          state_d = StIdle;
        end
      end
      // full_n is deliberately ignored until the word is complete.
      StB0: begin
        fd_d    = word_q[15:8];
        slwrn_d = 1'b0;
        state_d = StB1;
      end
      StB1: begin
        fd_d    = word_q[23:16];
        slwrn_d = 1'b0;
        state_d = StB2;
      end
      StB2: begin
        fd_d    = word_q[31:24];
        slwrn_d = 1'b0;
        state_d = StB3;
      end
      StPktend: begin
        byte_clr = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LevelW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LevelW'(1);
    end

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = clear_overflow ? 16'd1 : ((ovf_q == 16'hFFFF) ? ovf_q : ovf_q + 16'd1);
    end else if (clear_overflow) begin
      ovf_d = '0;
    end

    // Count wraps at PKT_BYTES, matching the FX2 auto-commit boundary.
    byte_cnt_d = byte_cnt_q;
    if (byte_clr) begin
      byte_cnt_d = '0;
    end else if (!slwrn_d) begin
      byte_cnt_d = byte_cnt_q + CntW'(1);
    end

    timer_d = timer_q;
    if (!slwrn_d || state_q == StPktend || byte_cnt_q == '0) begin
      timer_d = '0;
    end else if (state_q == StIdle && fifo_empty && timer_q != TimerMax) begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= '0;
      state_q    <= StIdle;
      word_q     <= '0;
      fd_q       <= '0;
      slwrn_q    <= 1'b1;
      pktendn_q  <= 1'b1;
      byte_cnt_q <= '0;
      timer_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      end
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      word_q     <= word_d;
      fd_q       <= fd_d;
      slwrn_q    <= slwrn_d;
      pktendn_q  <= pktendn_d;
      byte_cnt_q <= byte_cnt_d;
      timer_q    <= timer_d;
    end
  end

  assign fd             = fd_q;
  assign slwrn          = slwrn_q;
  assign pktendn        = pktendn_q;
  assign level          = level_q;
  assign overflow_count = ovf_q;

endmodule
